slow_clock_monitor: RTL

- Receiving end of the divided slow clock (SCLK) the design produces from CLK and switch settings.
- Synchronises SCLK into the CLK domain and emits one-cycle step pulses on each edge.
- Measures full period and high time in CLK cycles, flags rate changes, and detects a stalled clock (SW[15]=0 freezes the source).
- Sits between the slow-clock generator and the logic that advances on each slow tick; drives a status LED.

---
 rtl/slow_clock_monitor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/slow_clock_monitor.sv
// Receives the divided slow clock, resynchronises it into the CLK domain and
// reports its edges, period, high time, rate changes and stall condition.
module slow_clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 200000000
) (
  input  logic             CLK,
  input  logic             CPU_RESETN,
  input  logic             SCLK_IN,
  output logic             step_rise,
  output logic             step_fall,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             period_change,
  output logic             stalled,
  output logic             LED16_G
);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURING,
    LOCKED,
    STALLED
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   fall;
  logic                   timeout_hit;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_plus1;
  logic             rise_seen_q;

  logic latch_period;
  logic check_change;
  logic enter_stall;

  // The generator idles high, so the chain comes out of reset already high
  // and a steady-high SCLK_IN yields no spurious edge on release.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SCLK_IN};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

  // An edge arriving on the cycle the count would reach TIMEOUT wins over the stall.
  assign timeout_hit = !rise && (cnt_q >= TIMEOUT_M1);
  assign cnt_plus1   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= WAIT_FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FIRST: begin
        if (rise)             state_nxt = MEASURING;
        else if (timeout_hit) state_nxt = STALLED;
      end
      MEASURING: begin
        if (rise)             state_nxt = LOCKED;
        else if (timeout_hit) state_nxt = STALLED;
      end
      LOCKED: begin
        if (timeout_hit)      state_nxt = STALLED;
      end
      STALLED: begin
        if (rise)             state_nxt = MEASURING;
      end
      default:                state_nxt = WAIT_FIRST;
    endcase
  end

  // Output and datapath-control decode
  always_comb begin
    latch_period = 1'b0;
    check_change = 1'b0;
    enter_stall  = 1'b0;
    stalled      = 1'b0;
    period_valid = 1'b0;
    case (state)
      WAIT_FIRST: begin
        enter_stall = timeout_hit;
      end
      MEASURING: begin
        latch_period = rise;
        enter_stall  = timeout_hit;
      end
      LOCKED: begin
        latch_period = rise;
        check_change = rise;
        enter_stall  = timeout_hit;
        period_valid = 1'b1;
      end
      STALLED: begin
        stalled = 1'b1;
      end
      default: begin
        stalled = 1'b0;
      end
    endcase
  end

  // Cycle counter: restarts on each rise and parks at TIMEOUT.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= '0;
    end else if (cnt_q < TIMEOUT_C) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A high time only means something once a rise has started the count.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rise_seen_q <= 1'b0;
    end else if (rise) begin
      rise_seen_q <= 1'b1;
    end else if (enter_stall) begin
      rise_seen_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      period        <= '0;
      high_time     <= '0;
      period_change <= 1'b0;
    end else begin
      period_change <= check_change && (cnt_plus1 != period);
      if (latch_period) begin
        period <= cnt_plus1;
      end
      if (fall && rise_seen_q) begin
        high_time <= cnt_plus1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      step_rise <= 1'b0;
      step_fall <= 1'b0;
      LED16_G   <= 1'b0;
    end else begin
      step_rise <= rise;
      step_fall <= fall;
      LED16_G   <= LED16_G ^ rise;
    end
  end

endmodule
